// File: rtl/sim_ft_sync_fifo_model.sv
// Bench model of an FT2232H/FT232H-class synchronous FIFO port (RX source, TX checker).
// Define FT_LFSR_PATTERN_EN for 16-bit Galois LFSR word streams instead of counter streams.
module sim_ft_sync_fifo_model #(
    parameter int DATA_WIDTH = 8,
    parameter int RX_WORDS   = 256,
    parameter int TX_WORDS   = 256,
    parameter int RXF_BURST  = 0,
    parameter int RXF_GAP    = 4,
    parameter int TXE_BURST  = 0,
    parameter int TXE_HOLD   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  fifo_rxf_n_o,
    output logic                  fifo_txe_n_o,
    input  logic                  fifo_oe_n_i,
    input  logic                  fifo_rd_n_i,
    input  logic                  fifo_wr_n_i,
    input  logic                  fifo_siwu_i,
    output logic [DATA_WIDTH-1:0] fifo_data_o,
    output logic                  fifo_data_oe_o,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic [31:0]           rx_count_o,
    output logic [31:0]           tx_count_o,
    output logic [15:0]           err_count_o,
    output logic                  error_o,
    output logic                  done_o
);

    localparam logic [31:0] RX_N       = 32'(RX_WORDS);
    localparam logic [31:0] TX_N       = 32'(TX_WORDS);
    localparam logic [31:0] RX_BURST_N = 32'(RXF_BURST);
    localparam logic [31:0] TX_BURST_N = 32'(TXE_BURST);
    localparam logic [31:0] RX_GAP_M1  = 32'(RXF_GAP - 1);
    localparam logic [31:0] TX_HOLD_M1 = 32'(TXE_HOLD - 1);

`ifdef FT_LFSR_PATTERN_EN
    localparam logic [15:0] SEED = 16'hACE1;
`else
    localparam logic [15:0] SEED = 16'h0000;
`endif

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_ACTIVE,
        RX_GAP,
        RX_DONE,
        RX_HALT
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_READY,
        TX_HOLD,
        TX_DONE,
        TX_HALT
    } tx_state_t;

    function automatic logic [15:0] gen_step(input logic [15:0] s);
`ifdef FT_LFSR_PATTERN_EN
        gen_step = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
`else
        gen_step = s + 16'd1;
`endif
    endfunction

    rx_state_t rx_state, rx_state_nxt;
    tx_state_t tx_state, tx_state_nxt;

    logic [15:0] rx_gen, rx_gen_nxt;
    logic [15:0] tx_gen, tx_gen_nxt;
    logic [31:0] rx_burst, rx_burst_nxt;
    logic [31:0] rx_gap, rx_gap_nxt;
    logic [31:0] tx_burst, tx_burst_nxt;
    logic [31:0] tx_hold, tx_hold_nxt;
    logic [31:0] rx_count, rx_count_nxt;
    logic [31:0] tx_count, tx_count_nxt;
    logic [15:0] err_count, err_count_nxt;
    logic [16:0] err_sum;
    logic [DATA_WIDTH-1:0] data_q, data_nxt;

    logic error_q;
    logic done_q, done_nxt;
    logic rxf_n, txe_n;
    logic oe_prev;

    logic rd_err, wr_err;
    logic rx_xfer, tx_xfer;
    logic tx_bad, tx_good;
    logic [1:0] err_inc;
    logic halt;
    logic unused;

    // A read only counts if the bus was already turned around last cycle.
    assign rd_err  = ~fifo_rd_n_i & ~rxf_n & oe_prev;
    assign rx_xfer = ~fifo_rd_n_i & ~rxf_n & ~oe_prev & ~fifo_oe_n_i;
    assign wr_err  = ~fifo_wr_n_i & ~fifo_oe_n_i;
    assign tx_xfer = ~fifo_wr_n_i & ~txe_n & fifo_oe_n_i;
    assign tx_bad  = tx_xfer & (fifo_data_i != tx_gen[DATA_WIDTH-1:0]);
    assign tx_good = tx_xfer & ~tx_bad;
    assign err_inc = 2'(rd_err) + 2'(wr_err) + 2'(tx_bad);
    assign halt    = error_q | (err_inc != 2'd0);

    assign unused = ^{fifo_siwu_i, rx_gen, tx_gen};

    always_comb begin
        rx_state_nxt = rx_state;
        rx_gen_nxt   = rx_gen;
        rx_count_nxt = rx_count;
        rx_burst_nxt = rx_burst;
        rx_gap_nxt   = rx_gap;
        if (rx_xfer) begin
            rx_gen_nxt   = gen_step(rx_gen);
            rx_count_nxt = rx_count + 32'd1;
        end
        unique case (rx_state)
            RX_IDLE: begin
                rx_state_nxt = (RX_N != 32'd0) ? RX_ACTIVE : RX_DONE;
            end
            RX_ACTIVE: begin
                if (rx_xfer) begin
                    if (rx_count_nxt == RX_N) begin
                        rx_state_nxt = RX_DONE;
                    end else if (RX_BURST_N != 32'd0 &&
                                 rx_burst + 32'd1 == RX_BURST_N) begin
                        rx_state_nxt = RX_GAP;
                        rx_burst_nxt = '0;
                        rx_gap_nxt   = RX_GAP_M1;
                    end else begin
                        rx_burst_nxt = rx_burst + 32'd1;
                    end
                end
            end
            RX_GAP: begin
                if (rx_gap == 32'd0) begin
                    rx_state_nxt = RX_ACTIVE;
                end else begin
                    rx_gap_nxt = rx_gap - 32'd1;
                end
            end
            default: begin
            end
        endcase
        if (halt) begin
            rx_state_nxt = RX_HALT;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_gen_nxt   = tx_gen;
        tx_count_nxt = tx_count;
        tx_burst_nxt = tx_burst;
        tx_hold_nxt  = tx_hold;
        if (tx_good) begin
            tx_gen_nxt   = gen_step(tx_gen);
            tx_count_nxt = tx_count + 32'd1;
        end
        unique case (tx_state)
            TX_IDLE: begin
                tx_state_nxt = (TX_N != 32'd0) ? TX_READY : TX_DONE;
            end
            TX_READY: begin
                if (tx_good) begin
                    if (tx_count_nxt == TX_N) begin
                        tx_state_nxt = TX_DONE;
                    end else if (TX_BURST_N != 32'd0 &&
                                 tx_burst + 32'd1 == TX_BURST_N) begin
                        tx_state_nxt = TX_HOLD;
                        tx_burst_nxt = '0;
                        tx_hold_nxt  = TX_HOLD_M1;
                    end else begin
                        tx_burst_nxt = tx_burst + 32'd1;
                    end
                end
            end
            TX_HOLD: begin
                if (tx_hold == 32'd0) begin
                    tx_state_nxt = TX_READY;
                end else begin
                    tx_hold_nxt = tx_hold - 32'd1;
                end
            end
            default: begin
            end
        endcase
        if (halt) begin
            tx_state_nxt = TX_HALT;
        end
    end

    always_comb begin
        data_nxt = '0;
        if (rx_state_nxt == RX_ACTIVE || rx_state_nxt == RX_GAP) begin
            data_nxt = rx_gen_nxt[DATA_WIDTH-1:0];
        end
        err_sum       = {1'b0, err_count} + 17'(err_inc);
        err_count_nxt = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        done_nxt      = (rx_count_nxt == RX_N) &&
                        (tx_count_nxt == TX_N) && !halt;
    end

    always_ff @(posedge clk_i) begin
        oe_prev <= fifo_oe_n_i;
        if (rst_i) begin
            rx_state  <= RX_IDLE;
            tx_state  <= TX_IDLE;
            rx_gen    <= SEED;
            tx_gen    <= SEED;
            rx_burst  <= '0;
            rx_gap    <= '0;
            tx_burst  <= '0;
            tx_hold   <= '0;
            rx_count  <= '0;
            tx_count  <= '0;
            err_count <= '0;
            error_q   <= 1'b0;
            done_q    <= 1'b0;
            rxf_n     <= 1'b1;
            txe_n     <= 1'b1;
            data_q    <= '0;
        end else begin
            rx_state  <= rx_state_nxt;
            tx_state  <= tx_state_nxt;
            rx_gen    <= rx_gen_nxt;
            tx_gen    <= tx_gen_nxt;
            rx_burst  <= rx_burst_nxt;
            rx_gap    <= rx_gap_nxt;
            tx_burst  <= tx_burst_nxt;
            tx_hold   <= tx_hold_nxt;
            rx_count  <= rx_count_nxt;
            tx_count  <= tx_count_nxt;
            err_count <= err_count_nxt;
            error_q   <= halt;
            done_q    <= done_nxt;
            rxf_n     <= (rx_state_nxt != RX_ACTIVE);
            txe_n     <= (tx_state_nxt != TX_READY);
            data_q    <= data_nxt;
        end
    end

    assign fifo_rxf_n_o   = rxf_n;
    assign fifo_txe_n_o   = txe_n;
    assign fifo_data_o    = data_q;
    assign fifo_data_oe_o = ~fifo_oe_n_i;
    assign rx_count_o     = rx_count;
    assign tx_count_o     = tx_count;
    assign err_count_o    = err_count;
    assign error_o        = error_q;
    assign done_o         = done_q;

endmodule
